wowa_sar_ctrl: RTL and testbench

WOWA_SAR_CTRL -- requirements
Module: wowa_sar_ctrl

---
 rtl/wowa_sar_pkg.sv | 21 ++
 rtl/wowa_sar_if.sv | 34 +++
 rtl/wowa_settle_timer.sv | 25 ++
 rtl/wowa_sar_ctrl.sv | 145 ++++++++++++++
 tb/tb_wowa_sar_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/wowa_sar_pkg.sv
// Shared types and parameter defaults for the WOWA SAR ADC controller.
// Pass averaging is built only when WOWA_SAR_AVG_EN is defined.
package wowa_sar_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NCH      = 2;
    localparam int DEF_SETTLE   = 4;
    localparam int DEF_AVG_LOG2 = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        TRIAL = 2'd2,
        DONE  = 2'd3
    } sar_state_e;

    function automatic int cw_of(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/wowa_sar_if.sv
// Request/analog bundle between a SAR controller (slave) and its user and
// analog front end (master).
interface wowa_sar_if
    import wowa_sar_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH
) ();
    localparam int CW = cw_of(NCH);

    logic             start;
    logic [CW-1:0]    chan;
    logic             busy;
    logic [WIDTH-1:0] dac_set;
    logic [CW-1:0]    chan_sel;
    logic             comparator_nen;
    logic             analog_comparator_out;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    result_chan;

    modport master (
        output start, chan, analog_comparator_out,
        input  busy, dac_set, chan_sel, comparator_nen,
        input  result_ready, result, result_chan
    );

    modport slave (
        input  start, chan, analog_comparator_out,
        output busy, dac_set, chan_sel, comparator_nen,
        output result_ready, result, result_chan
    );

endinterface

// File: rtl/wowa_settle_timer.sv
// Down-counter timing one SETTLE window; done marks the window's last cycle.
module wowa_settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic done
);
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'(SETTLE - 1);
        end else if (count && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign done = count && (cnt == 8'd0);

endmodule

// File: rtl/wowa_sar_ctrl.sv
// SAR ADC conversion sequencer: warm-up, one trial per bit, done pulse.
// Define WOWA_SAR_AVG_EN to average 2^AVG_LOG2 trial passes per conversion.
module wowa_sar_ctrl
    import wowa_sar_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NCH      = DEF_NCH,
    parameter int SETTLE   = DEF_SETTLE,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic      clk,
    input  logic      rst,
    wowa_sar_if.slave bus
);
    localparam int CW = cw_of(NCH);
    localparam int BW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WARM  = WARM;
    localparam logic [1:0] ST_TRIAL = TRIAL;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] code;
    logic [BW-1:0]    bit_idx;
    logic [CW-1:0]    chan_sel;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    result_chan;
    logic             cmp_q1;
    logic             cmp_q2;
    logic             tmr_done;
    logic             last_pass;
    logic [WIDTH-1:0] out_code;

    logic             accept;
    logic             last_bit;
    logic             finish;
    logic [WIDTH-1:0] trial_code;
    logic [WIDTH-1:0] final_code;
    logic [CW-1:0]    chan_clamped;

    assign accept     = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign last_bit   = (bit_idx == '0);
    assign trial_code = code | (WIDTH'(1) << bit_idx);
    assign final_code = cmp_q2 ? trial_code : code;
    assign finish     = (state == ST_TRIAL) && tmr_done && last_bit && last_pass;

    assign chan_clamped = (int'(bus.chan) >= NCH) ? CW'(NCH - 1) : bus.chan;

    wowa_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (accept || (tmr_done && !finish)),
        .count (state == ST_WARM || state == ST_TRIAL),
        .done  (tmr_done)
    );

`ifdef WOWA_SAR_AVG_EN
    localparam int AW = WIDTH + AVG_LOG2;
    localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [AW-1:0] acc;
    logic [PW-1:0] pass;
    logic [AW-1:0] sum;

    assign sum       = acc + AW'(final_code);
    assign last_pass = (AVG_LOG2 == 0) || (pass == PW'((1 << AVG_LOG2) - 1));
    assign out_code  = WIDTH'(sum >> AVG_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            pass <= '0;
        end else if (state == ST_WARM) begin
            acc  <= '0;
            pass <= '0;
        end else if (state == ST_TRIAL && tmr_done && last_bit && !last_pass) begin
            acc  <= sum;
            pass <= pass + PW'(1);
        end
    end
`else
    // single pass for any legal AVG_LOG2
    assign last_pass = (AVG_LOG2 >= 0);
    assign out_code  = final_code;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            code        <= '0;
            bit_idx     <= '0;
            chan_sel    <= '0;
            result      <= '0;
            result_chan <= '0;
            cmp_q1      <= 1'b0;
            cmp_q2      <= 1'b0;
        end else begin
            cmp_q1 <= bus.analog_comparator_out;
            cmp_q2 <= cmp_q1;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state    <= ST_WARM;
                        chan_sel <= chan_clamped;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WARM: begin
                    if (tmr_done) begin
                        state   <= ST_TRIAL;
                        code    <= '0;
                        bit_idx <= BW'(WIDTH - 1);
                    end
                end
                ST_TRIAL: begin
                    if (tmr_done) begin
                        if (!last_bit) begin
                            code    <= final_code;
                            bit_idx <= bit_idx - BW'(1);
                        end else if (!last_pass) begin
                            code    <= '0;
                            bit_idx <= BW'(WIDTH - 1);
                        end else begin
                            state       <= ST_DONE;
                            result      <= out_code;
                            result_chan <= chan_sel;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy           = (state != ST_IDLE);
    assign bus.dac_set        = (state == ST_TRIAL) ? trial_code : '0;
    assign bus.chan_sel       = chan_sel;
    assign bus.comparator_nen = (state == ST_IDLE);
    assign bus.result_ready   = (state == ST_DONE);
    assign bus.result         = result;
    assign bus.result_chan    = result_chan;

endmodule

// File: tb/tb_wowa_sar_ctrl.sv
// Self-checking bench for wowa_sar_ctrl with an ideal comparator model.
// Define WOWA_SAR_AVG_EN to also exercise pass averaging.
module tb_wowa_sar_ctrl;
    localparam int WIDTH    = 8;
    localparam int NCH      = 4;
    localparam int SETTLE   = 4;
    localparam int AVG_LOG2 = 2;
`ifdef WOWA_SAR_AVG_EN
    localparam int LAT = SETTLE * (1 + WIDTH * (1 << AVG_LOG2));
`else
    localparam int LAT = SETTLE * (WIDTH + 1);
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    wowa_sar_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    wowa_sar_ctrl #(
        .WIDTH(WIDTH), .NCH(NCH), .SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // comparator: mode 0 ideal (input half an LSB above vin), 1 stuck high, 2 stuck low
    int         mode = 0;
    logic [7:0] vin_a = 8'h00;
    logic [7:0] vin_b = 8'h00;
    logic [7:0] prev_dac = 8'h00;
    logic       odd = 1'b0;
    logic [7:0] vin_now;

    assign vin_now = odd ? vin_a : vin_b;
    assign bus.analog_comparator_out = (mode == 1) ? 1'b1 :
                                       (mode == 2) ? 1'b0 :
                                       (bus.dac_set <= vin_now);

    always @(posedge clk) begin
        prev_dac <= bus.dac_set;
        if (!bus.busy) odd <= 1'b0;
        else if (bus.dac_set == 8'h80 && prev_dac != 8'h80) odd <= ~odd;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] res;
        logic [1:0] ch;
        int         due;
    } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;
    int ready_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.result_ready === 1'b1) begin
            ready_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected result_ready", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", bus.result, e.res);
                chk("result_chan", bus.result_chan, e.ch);
                chk("ready latency", cyc, e.due);
            end
        end
    end

    // called just after a negedge; start is sampled at the following posedge
    task automatic kick(input logic [1:0] ch, input logic [7:0] res, output int e0);
        bus.start = 1'b1;
        bus.chan  = ch;
        @(posedge clk);
        #1;
        e0 = cyc;
        bus.start = 1'b0;
        sbq.push_back('{res: res, ch: ch, due: e0 + LAT});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus.busy || sbq.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, " timeout"}, (n < 400), 1);
        if (n >= 400) sbq.delete();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " dac_set"}, bus.dac_set, 0);
        chk({tag, " chan_sel"}, bus.chan_sel, 0);
        chk({tag, " comparator_nen"}, bus.comparator_nen, 1);
        chk({tag, " result_ready"}, bus.result_ready, 0);
        chk({tag, " result"}, bus.result, 0);
        chk({tag, " result_chan"}, bus.result_chan, 0);
    endtask

    typedef struct {
        int         mode;
        logic [7:0] vin;
        logic [1:0] ch;
        logic [7:0] res;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int e0;
        int rc;

        tbl[0] = '{0, 8'hA5, 2'd1, 8'hA5};
        tbl[1] = '{0, 8'h00, 2'd0, 8'h00};
        tbl[2] = '{0, 8'hFF, 2'd3, 8'hFF};
        tbl[3] = '{0, 8'h01, 2'd2, 8'h01};
        tbl[4] = '{0, 8'h80, 2'd1, 8'h80};
        tbl[5] = '{0, 8'h7F, 2'd0, 8'h7F};
        tbl[6] = '{1, 8'h00, 2'd2, 8'hFF};
        tbl[7] = '{2, 8'hFF, 2'd3, 8'h00};

        bus.start = 1'b0;
        bus.chan  = 2'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            mode  = tbl[i].mode;
            vin_a = tbl[i].vin;
            vin_b = tbl[i].vin;
            kick(tbl[i].ch, tbl[i].res, e0);
            if (i == 0) begin
                @(negedge clk);
                chk("warm busy", bus.busy, 1);
                chk("warm nen", bus.comparator_nen, 0);
                chk("warm dac_set", bus.dac_set, 8'h00);
                chk("warm chan_sel", bus.chan_sel, tbl[i].ch);
                repeat (4) @(negedge clk);
                chk("bit7 dac_set", bus.dac_set, 8'h80);
                repeat (4) @(negedge clk);
                chk("bit6 dac_set", bus.dac_set, 8'hC0);
                chk("trial nen", bus.comparator_nen, 0);
            end
            wait_idle("vector");
            chk("idle nen", bus.comparator_nen, 1);
            chk("idle dac_set", bus.dac_set, 0);
        end

        // asynchronous reset twenty cycles into a conversion
        mode  = 0;
        vin_a = 8'h5A;
        vin_b = 8'h5A;
        bus.start = 1'b1;
        bus.chan  = 2'd2;
        @(posedge clk);
        #1;
        e0 = cyc;
        bus.start = 1'b0;
        while (cyc < e0 + 20) @(negedge clk);
        rc = ready_cnt;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("no ready after reset", ready_cnt, rc);

        // first conversion after reset runs in full
        vin_a = 8'h3C;
        vin_b = 8'h3C;
        kick(2'd2, 8'h3C, e0);
        wait_idle("post reset");

        // a start pulse while busy is ignored
        rc = ready_cnt;
        vin_a = 8'h66;
        vin_b = 8'h66;
        kick(2'd0, 8'h66, e0);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.chan  = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("busy start");
        chk("single ready", ready_cnt - rc, 1);

        // start held high: back-to-back conversions on channels 3 then 1
        vin_a = 8'h33;
        vin_b = 8'h33;
        bus.start = 1'b1;
        bus.chan  = 2'd3;
        @(posedge clk);
        #1;
        e0 = cyc;
        sbq.push_back('{res: 8'h33, ch: 2'd3, due: e0 + LAT});
        bus.chan = 2'd1;
        @(negedge clk);
        chk("b2b chan_sel first", bus.chan_sel, 3);
        while (cyc < e0 + LAT + 1) @(negedge clk);
        chk("b2b chan_sel second", bus.chan_sel, 1);
        chk("b2b busy", bus.busy, 1);
        sbq.push_back('{res: 8'h33, ch: 2'd1, due: e0 + 2 * LAT + 1});
        bus.start = 1'b0;
        wait_idle("back to back");

`ifdef WOWA_SAR_AVG_EN
        vin_a = 8'h40;
        vin_b = 8'h43;
        kick(2'd1, 8'h41, e0);
        wait_idle("average");
`endif

        chk("scoreboard drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
